// File: rtl/color_sensor_pkg.sv
// color_sensor_pkg: shared encodings for the colour-sensor front end.
// Filter select codes (S2,S3), published colour codes, FSM state and
// channel enums, plus a channel-to-filter mapping helper.
package color_sensor_pkg;

  localparam logic [1:0] RED_FILTER   = 2'd0;
  localparam logic [1:0] BLUE_FILTER  = 2'd1;
  localparam logic [1:0] CLEAR_FILTER = 2'd2;
  localparam logic [1:0] GREEN_FILTER = 2'd3;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] RED   = 2'd1;
  localparam logic [1:0] GREEN = 2'd2;
  localparam logic [1:0] BLUE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    COUNT    = 2'd2,
    CLASSIFY = 2'd3
  } state_t;

  // Channels are visited in this order within a frame.
  typedef enum logic [1:0] {
    CH_GREEN = 2'd0,
    CH_RED   = 2'd1,
    CH_BLUE  = 2'd2
  } chan_t;

  function automatic logic [1:0] chan_filter(input chan_t ch);
    logic [1:0] f;
    case (ch)
      CH_GREEN: f = GREEN_FILTER;
      CH_RED:   f = RED_FILTER;
      CH_BLUE:  f = BLUE_FILTER;
      default:  f = CLEAR_FILTER;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/cs_edge_sync.sv
// cs_edge_sync: brings the asynchronous sensor output into the clk domain
// with a 2-FF synchroniser and emits a registered one-cycle pulse for
// every synchronised rising edge.
module cs_edge_sync
  import color_sensor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchroniser chain, previous-level register and registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      pulse   <= sync2_r & ~prev_r;
    end
  end

endmodule

// File: rtl/color_sensor_ctrl.sv
// color_sensor_ctrl: sequences the sensor filter green -> red -> blue,
// counts synchronised sensor edges in a fixed window per channel, then
// classifies the frame and publishes colour, match and raw counts with a
// one-cycle frame_valid strobe.
// Build macro COLOR_HYST_EN: colour only follows a winner that repeats over
// two consecutive matching frames (history is cleared on reset and in IDLE).
module color_sensor_ctrl
  import color_sensor_pkg::*;
#(
  parameter int         CNT_W         = 8,
  parameter int         WINDOW_CYCLES = 511,
  parameter int         SETTLE_CYCLES = 16,
  parameter logic [1:0] SCALE         = 2'b11,
  parameter int         R_MIN         = 15,
  parameter int         R_MAX         = 50,
  parameter int         G_MIN         = 20,
  parameter int         G_MAX         = 40,
  parameter int         B_MIN         = 15,
  parameter int         B_MAX         = 40,
  parameter int         MARGIN        = 0
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cs_out,
  output logic [1:0]       filter,
  output logic [1:0]       cs_scaler,
  output logic [1:0]       color,
  output logic             match,
  output logic             frame_valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  localparam int CYC_W = $clog2((WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES) + 1;
  localparam int CW    = CNT_W + 1;
  localparam logic [CYC_W-1:0] CYC_ZERO    = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  // Thresholds widened by one bit so "count + MARGIN" cannot wrap.
  localparam logic [CNT_W:0] R_MIN_W  = CW'(R_MIN);
  localparam logic [CNT_W:0] R_MAX_W  = CW'(R_MAX);
  localparam logic [CNT_W:0] G_MIN_W  = CW'(G_MIN);
  localparam logic [CNT_W:0] G_MAX_W  = CW'(G_MAX);
  localparam logic [CNT_W:0] B_MIN_W  = CW'(B_MIN);
  localparam logic [CNT_W:0] B_MAX_W  = CW'(B_MAX);
  localparam logic [CNT_W:0] MARGIN_W = CW'(MARGIN);

  state_t           state_r;
  chan_t            chan_r;
  logic [CYC_W-1:0] cyc_r;
  logic [CNT_W-1:0] red_acc_r;
  logic [CNT_W-1:0] green_acc_r;
  logic [CNT_W-1:0] blue_acc_r;
  logic             edge_pulse_s;
  logic [CNT_W-1:0] cur_acc_s;
  logic [CNT_W-1:0] acc_inc_s;
  logic [CNT_W:0]   r_w_s;
  logic [CNT_W:0]   g_w_s;
  logic [CNT_W:0]   b_w_s;
  logic             r_q_s;
  logic             g_q_s;
  logic             b_q_s;
  logic             qualify_s;
  logic [1:0]       winner_s;
`ifdef COLOR_HYST_EN
  logic [1:0]       prev_winner_r;
  logic             prev_match_r;
`endif

  cs_edge_sync u_sync (
    .clk   (clk_1MHz),
    .rst_n (rst_n),
    .din   (cs_out),
    .pulse (edge_pulse_s)
  );

  // Saturating increment of the accumulator for the channel being counted.
  always_comb begin
    cur_acc_s = green_acc_r;
    case (chan_r)
      CH_RED:  cur_acc_s = red_acc_r;
      CH_BLUE: cur_acc_s = blue_acc_r;
      default: cur_acc_s = green_acc_r;
    endcase
    if (edge_pulse_s && (cur_acc_s != CNT_MAX)) begin
      acc_inc_s = cur_acc_s + CNT_W'(1);
    end else begin
      acc_inc_s = cur_acc_s;
    end
  end

  // Frame classification: in-range and strictly above both others by MARGIN.
  always_comb begin
    r_w_s = {1'b0, red_acc_r};
    g_w_s = {1'b0, green_acc_r};
    b_w_s = {1'b0, blue_acc_r};
    r_q_s = (r_w_s >= R_MIN_W) && (r_w_s <= R_MAX_W) &&
            (r_w_s > (g_w_s + MARGIN_W)) && (r_w_s > (b_w_s + MARGIN_W));
    g_q_s = (g_w_s >= G_MIN_W) && (g_w_s <= G_MAX_W) &&
            (g_w_s > (r_w_s + MARGIN_W)) && (g_w_s > (b_w_s + MARGIN_W));
    b_q_s = (b_w_s >= B_MIN_W) && (b_w_s <= B_MAX_W) &&
            (b_w_s > (r_w_s + MARGIN_W)) && (b_w_s > (g_w_s + MARGIN_W));
    qualify_s = r_q_s | g_q_s | b_q_s;
    if (r_q_s) begin
      winner_s = RED;
    end else if (g_q_s) begin
      winner_s = GREEN;
    end else if (b_q_s) begin
      winner_s = BLUE;
    end else begin
      winner_s = NONE;
    end
  end

  // Frame sequencer with registered pin and result outputs.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      chan_r      <= CH_GREEN;
      cyc_r       <= CYC_ZERO;
      red_acc_r   <= CNT_ZERO;
      green_acc_r <= CNT_ZERO;
      blue_acc_r  <= CNT_ZERO;
      filter      <= CLEAR_FILTER;
      cs_scaler   <= 2'b00;
      color       <= NONE;
      match       <= 1'b0;
      frame_valid <= 1'b0;
      red_cnt     <= CNT_ZERO;
      green_cnt   <= CNT_ZERO;
      blue_cnt    <= CNT_ZERO;
`ifdef COLOR_HYST_EN
      prev_winner_r <= NONE;
      prev_match_r  <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          cyc_r <= CYC_ZERO;
          if (en) begin
            state_r   <= SETTLE;
            chan_r    <= CH_GREEN;
            filter    <= chan_filter(CH_GREEN);
            cs_scaler <= SCALE;
          end else begin
            filter    <= CLEAR_FILTER;
            cs_scaler <= 2'b00;
          end
        end
        SETTLE: begin
          case (chan_r)
            CH_RED:  red_acc_r   <= CNT_ZERO;
            CH_BLUE: blue_acc_r  <= CNT_ZERO;
            default: green_acc_r <= CNT_ZERO;
          endcase
          if (cyc_r == SETTLE_LAST) begin
            cyc_r   <= CYC_ZERO;
            state_r <= COUNT;
          end else begin
            cyc_r <= cyc_r + CYC_W'(1);
          end
        end
        COUNT: begin
          case (chan_r)
            CH_RED:  red_acc_r   <= acc_inc_s;
            CH_BLUE: blue_acc_r  <= acc_inc_s;
            default: green_acc_r <= acc_inc_s;
          endcase
          if (cyc_r == WINDOW_LAST) begin
            cyc_r <= CYC_ZERO;
            case (chan_r)
              CH_GREEN: begin
                chan_r  <= CH_RED;
                filter  <= chan_filter(CH_RED);
                state_r <= SETTLE;
              end
              CH_RED: begin
                chan_r  <= CH_BLUE;
                filter  <= chan_filter(CH_BLUE);
                state_r <= SETTLE;
              end
              default: state_r <= CLASSIFY;
            endcase
          end else begin
            cyc_r <= cyc_r + CYC_W'(1);
          end
        end
        CLASSIFY: begin
          red_cnt     <= red_acc_r;
          green_cnt   <= green_acc_r;
          blue_cnt    <= blue_acc_r;
          match       <= qualify_s;
          frame_valid <= 1'b1;
`ifdef COLOR_HYST_EN
          if (qualify_s && prev_match_r && (winner_s == prev_winner_r)) begin
            color <= winner_s;
          end
          prev_winner_r <= winner_s;
          prev_match_r  <= qualify_s;
`else
          if (qualify_s) begin
            color <= winner_s;
          end
`endif
          cyc_r <= CYC_ZERO;
          if (en) begin
            state_r   <= SETTLE;
            chan_r    <= CH_GREEN;
            filter    <= chan_filter(CH_GREEN);
            cs_scaler <= SCALE;
          end else begin
            state_r   <= IDLE;
            chan_r    <= CH_GREEN;
            filter    <= CLEAR_FILTER;
            cs_scaler <= 2'b00;
`ifdef COLOR_HYST_EN
            prev_match_r <= 1'b0;
`endif
          end
        end
        default: begin
          state_r   <= IDLE;
          filter    <= CLEAR_FILTER;
          cs_scaler <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_sensor_ctrl.sv
// tb_color_sensor_ctrl: randomized self-checking bench for color_sensor_ctrl.
// Frames are built as per-cycle cs_out waveforms; expected counts and
// colour come from an arithmetic model of the classification rules.
`timescale 1ns/1ps
module tb_color_sensor_ctrl;

  localparam int SET   = 16;
  localparam int WIN   = 511;
  localparam int FRAME = 3 * (SET + WIN) + 1;
  localparam int SAT_WIN   = 1300;
  localparam int SAT_FRAME = 3 * (SET + SAT_WIN) + 1;
  localparam int CMAX  = 255;

  logic       clk = 1'b0;
  logic       rst_n, en, cs_out, en_sat, cs_out_sat;
  logic [1:0] filter, cs_scaler, color;
  logic       match, frame_valid;
  logic [7:0] red_cnt, green_cnt, blue_cnt;
  logic [1:0] filter_sat, cs_scaler_sat, color_sat;
  logic       match_sat, frame_valid_sat;
  logic [7:0] red_cnt_sat, green_cnt_sat, blue_cnt_sat;

  int n_pass = 0;
  int n_total = 0;
  int m_color, m_prev_win, m_prev_match;
  bit wave [0:FRAME-1];

  always #500 clk = ~clk;

  color_sensor_ctrl dut (
    .clk_1MHz(clk), .rst_n(rst_n), .en(en), .cs_out(cs_out),
    .filter(filter), .cs_scaler(cs_scaler), .color(color), .match(match),
    .frame_valid(frame_valid), .red_cnt(red_cnt), .green_cnt(green_cnt),
    .blue_cnt(blue_cnt)
  );

  color_sensor_ctrl #(.WINDOW_CYCLES(SAT_WIN)) dut_sat (
    .clk_1MHz(clk), .rst_n(rst_n), .en(en_sat), .cs_out(cs_out_sat),
    .filter(filter_sat), .cs_scaler(cs_scaler_sat), .color(color_sat),
    .match(match_sat), .frame_valid(frame_valid_sat), .red_cnt(red_cnt_sat),
    .green_cnt(green_cnt_sat), .blue_cnt(blue_cnt_sat)
  );

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Winner code from the qualification rule (MARGIN 0), 0 when none.
  function automatic int classify(input int g, input int r, input int b);
    if (r >= 15 && r <= 50 && r > g && r > b) return 1;
    if (g >= 20 && g <= 40 && g > r && g > b) return 2;
    if (b >= 15 && b <= 40 && b > r && b > g) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_color = 0; m_prev_win = 0; m_prev_match = 0;
  endtask

  task automatic build_wave(input int ng, input int nr, input int nb);
    int pos, n, hi, lo, base;
    for (int i = 0; i < FRAME; i++) wave[i] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      base = c * (SET + WIN);
      wave[base + 1] = 1'b1;   // edge inside the settle interval, must be ignored
      wave[base + 2] = 1'b1;
      n = (c == 0) ? ng : ((c == 1) ? nr : nb);
      pos = base + SET + 4;
      for (int k = 0; k < n; k++) begin
        hi = 2 + int'($urandom_range(0, 1));
        lo = 2 + int'($urandom_range(0, 1));
        for (int j = 0; j < hi; j++) wave[pos + j] = 1'b1;
        pos = pos + hi + lo;
      end
    end
  endtask

  task automatic start_from_idle();
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one frame starting in its first SETTLE cycle and checks the publish.
  task automatic run_frame(input int ng, input int nr, input int nb, input int drop_at, input string name);
    bit fv_seen;
    logic [1:0] exp_f;
    int w;
    build_wave(ng, nr, nb);
    fv_seen = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      cs_out = wave[i];
      if (i == drop_at) en = 1'b0;
      if (i > 0 && frame_valid === 1'b1) fv_seen = 1'b1;
      if (i == 0 || i == 526 || i == 527 || i == 1053 || i == 1054 || i == 1581) begin
        exp_f = (i < 527) ? 2'd3 : ((i < 1054) ? 2'd0 : 2'd1);
        n_total++;
        if (filter !== exp_f || cs_scaler !== 2'b11)
          $display("FAIL %s filter@%0d got %0d/%0d exp %0d/3", name, i, filter, cs_scaler, exp_f);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    cs_out = 1'b0;
    w = classify(sat(ng), sat(nr), sat(nb));
`ifdef COLOR_HYST_EN
    if (w != 0 && m_prev_match != 0 && w == m_prev_win) m_color = w;
    m_prev_match = (w != 0); m_prev_win = w;
`else
    if (w != 0) m_color = w;
`endif
    n_total++;
    if (fv_seen !== 1'b0 || frame_valid !== 1'b1)
      $display("FAIL %s frame_valid timing early=%0d at_%0d=%0d exp 0/1", name, fv_seen, FRAME, frame_valid);
    else n_pass++;
    n_total++;
    if (green_cnt !== sat(ng) || red_cnt !== sat(nr) || blue_cnt !== sat(nb))
      $display("FAIL %s counts got g%0d r%0d b%0d exp g%0d r%0d b%0d", name,
               green_cnt, red_cnt, blue_cnt, sat(ng), sat(nr), sat(nb));
    else n_pass++;
    n_total++;
    if (match !== (w != 0) || color !== m_color)
      $display("FAIL %s result got match%0d color%0d exp match%0d color%0d", name, match, color, (w != 0), m_color);
    else n_pass++;
    if (!en) begin
      m_prev_match = 0;
      n_total++;
      if (filter !== 2'd2 || cs_scaler !== 2'd0)
        $display("FAIL %s idle pins got %0d/%0d exp 2/0", name, filter, cs_scaler);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    bit fv_seen = 1'b0;
    rst_n = 1'b0; en = 1'b1; en_sat = 1'b0; cs_out = 1'b0; cs_out_sat = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cs_out = i[1];
      if (frame_valid !== 1'b0) fv_seen = 1'b1;
    end
    n_total++;
    if (filter !== 2'd2 || cs_scaler !== 2'd0 || color !== 2'd0 || match !== 1'b0 || fv_seen)
      $display("FAIL reset outputs got f%0d s%0d c%0d m%0d fv%0d exp 2 0 0 0 0", filter, cs_scaler, color, match, fv_seen);
    else n_pass++;
    n_total++;
    if (red_cnt !== 8'd0 || green_cnt !== 8'd0 || blue_cnt !== 8'd0)
      $display("FAIL reset counts got %0d %0d %0d exp 0", red_cnt, green_cnt, blue_cnt);
    else n_pass++;
    en = 1'b0; cs_out = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_red_frame();
    start_from_idle();
    run_frame(10, 30, 10, -1, "red_frame");
  endtask

  task automatic test_tie();
    run_frame(25, 25, 25, -1, "tie");
  endtask

  task automatic test_back_to_back_random();
    int sel, g, r, b;
    for (int f = 0; f < 4; f++) begin
      sel = int'($urandom_range(0, 3));
      g = int'($urandom_range(0, 14)); r = int'($urandom_range(0, 14)); b = int'($urandom_range(0, 14));
      case (sel)
        0: begin g = int'($urandom_range(0, 60)); r = int'($urandom_range(0, 60)); b = int'($urandom_range(0, 60)); end
        1: r = int'($urandom_range(15, 50));
        2: g = int'($urandom_range(20, 40));
        default: b = int'($urandom_range(15, 40));
      endcase
      run_frame(g, r, b, -1, "random");
    end
  endtask

  task automatic test_en_drop();
    bit fv_seen = 1'b0;
    run_frame(12, 35, 8, 700, "en_drop");
    for (int i = 0; i < FRAME + 100; i++) begin
      @(posedge clk); #1;
      if (frame_valid !== 1'b0 || filter !== 2'd2 || cs_scaler !== 2'd0) fv_seen = 1'b1;
    end
    n_total++;
    if (fv_seen) $display("FAIL en_drop idle activity got 1 exp 0");
    else n_pass++;
  endtask

  task automatic test_hysteresis();
    start_from_idle();
    run_frame(10, 5, 30, -1, "hyst_blue");
    run_frame(30, 10, 10, -1, "hyst_green1");
    run_frame(30, 10, 10, 100, "hyst_green2");
  endtask

  task automatic test_saturation();
    int fv_cycle = -1;
    bit v;
    en_sat = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < SAT_FRAME + 50 && fv_cycle < 0; i++) begin
      v = (i >= 20 && i < 1220 && ((i - 20) % 4) < 2) ||
          (i == 1 || i == 2 || i == 1317 || i == 1318 || i == 2633 || i == 2634);
      cs_out_sat = v;
      if (i == 10) en_sat = 1'b0;
      if (i > 0 && frame_valid_sat === 1'b1) fv_cycle = i;
      @(posedge clk); #1;
    end
    cs_out_sat = 1'b0;
    n_total++;
    if (fv_cycle != SAT_FRAME) $display("FAIL sat frame_valid cycle got %0d exp %0d", fv_cycle, SAT_FRAME);
    else n_pass++;
    n_total++;
    if (green_cnt_sat !== 8'd255 || red_cnt_sat !== 8'd0 || blue_cnt_sat !== 8'd0)
      $display("FAIL sat counts got g%0d r%0d b%0d exp g255 r0 b0", green_cnt_sat, red_cnt_sat, blue_cnt_sat);
    else n_pass++;
    n_total++;
    if (match_sat !== 1'b0 || color_sat !== 2'd0)
      $display("FAIL sat result got m%0d c%0d exp m0 c0", match_sat, color_sat);
    else n_pass++;
  endtask

  task automatic test_abort();
    bit fv_seen = 1'b0;
    start_from_idle();
    repeat (600) @(posedge clk);
    #200 rst_n = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (filter !== 2'd2 || cs_scaler !== 2'd0 || color !== 2'd0 || match !== 1'b0 || frame_valid !== 1'b0 || red_cnt !== 8'd0)
      $display("FAIL abort outputs got f%0d s%0d c%0d m%0d fv%0d r%0d exp 2 0 0 0 0 0",
               filter, cs_scaler, color, match, frame_valid, red_cnt);
    else n_pass++;
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 100; i++) begin
      @(posedge clk); #1;
      if (frame_valid !== 1'b0) fv_seen = 1'b1;
    end
    n_total++;
    if (fv_seen) $display("FAIL abort partial frame_valid got 1 exp 0");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_red_frame();
    test_tie();
    test_back_to_back_random();
    test_en_drop();
    test_hysteresis();
    test_saturation();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
